ffe_tap_sequencer: RTL and testbench

- Parametrised control sequencer for the FFE datapath. It generalises the fixed 4-tap controller to NUM_TAPS taps, with a runtime-selectable active tap count.
- Adds a valid/ready sample handshake, coefficient-update arbitration and explicit accumulator-clear and store strobes.
- Sits between the sample source and the FFE delay line, the coefficient memory and the MAC accumulator.

---
 rtl/ffe_pkg.sv | 21 ++
 rtl/ffe_tap_counter.sv | 33 +++
 rtl/ffe_tap_sequencer.sv | 135 +++++++++++++
 tb/tb_ffe_tap_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ffe_pkg.sv
// ffe_pkg: shared definitions for the FFE tap sequencer.
//   ffe_state_t : sequencer state encoding (RESET, IDLE, COMPUTE, COEF_UPD)
//   clamp_taps  : maps a requested tap count onto the legal range 1..max_taps
package ffe_pkg;

  typedef enum logic [1:0] {
    RESET    = 2'd0,
    IDLE     = 2'd1,
    COMPUTE  = 2'd2,
    COEF_UPD = 2'd3
  } ffe_state_t;

  // A request of 0 taps still computes one tap; oversize requests saturate.
  function automatic int unsigned clamp_taps(input int unsigned taps,
                                             input int unsigned max_taps);
    if (taps == 0) return 1;
    else if (taps > max_taps) return max_taps;
    else return taps;
  endfunction

endpackage

// File: rtl/ffe_tap_counter.sv
// ffe_tap_counter: loadable down-counter holding the tap read address.
//   ffe_clk  : clock
//   rst      : asynchronous active-high reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value loaded on load
//   dec      : decrement by one
//   count    : current tap address
//   zero     : count == 0
module ffe_tap_counter #(
  parameter int unsigned ADDR_SIZE = 2
) (
  input  logic                 ffe_clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ADDR_SIZE-1:0] load_val,
  input  logic                 dec,
  output logic [ADDR_SIZE-1:0] count,
  output logic                 zero
);

  always_ff @(posedge ffe_clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - ADDR_SIZE'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ffe_tap_sequencer.sv
// ffe_tap_sequencer: control sequencer for the FFE datapath.
// Accepts one sample per valid/ready handshake, then walks the coefficient/tap
// read address from taps_eff-1 down to 0, issuing accumulator clear and store
// strobes. Coefficient updates are granted only while the MAC is quiescent.
// Optional build macro: FFE_MAC_PIPE_EN (one extra MAC register stage; clear
// and store strobes, and entry into the update grant, move one cycle later).
// Ports:
//   ffe_clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready     : sample handshake
//   taps_active             : requested tap count, sampled on acceptance
//   coef_upd_req / _gnt     : coefficient-memory access request / grant
//   shift_en                : shift accepted sample into the delay line
//   rd_en, rd_addr          : coefficient/tap read strobe and address
//   acc_clr                 : first tap of a sample (accumulator loads)
//   str_out_n_rst_add_reg   : store accumulator to the output register
//   busy                    : sample computation in flight
module ffe_tap_sequencer
  import ffe_pkg::*;
#(
  parameter int unsigned NUM_TAPS  = 4,
  parameter int unsigned ADDR_SIZE = $clog2(NUM_TAPS)
) (
  input  logic                 ffe_clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_SIZE:0]   taps_active,
  input  logic                 coef_upd_req,
  output logic                 coef_upd_gnt,
  output logic                 shift_en,
  output logic                 rd_en,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic                 acc_clr,
  output logic                 str_out_n_rst_add_reg,
  output logic                 busy
);

`ifdef FFE_MAC_PIPE_EN
  // Pass through IDLE first so the delayed store lands before the grant.
  localparam ffe_state_t UPD_AFTER_LAST = IDLE;
`else
  localparam ffe_state_t UPD_AFTER_LAST = COEF_UPD;
`endif

  ffe_state_t           state_q, state_d;
  logic                 accept;
  logic                 zero;
  logic                 last_tap;
  logic                 first_q;
  logic                 store_q;
  logic [ADDR_SIZE-1:0] load_val;

  assign load_val = ADDR_SIZE'(clamp_taps(32'(taps_active), NUM_TAPS) - 1);
  assign accept   = in_valid & in_ready;
  assign shift_en = accept;
  assign last_tap = (state_q == COMPUTE) && zero;

  always_ff @(posedge ffe_clk or posedge rst) begin
    if (rst) state_q <= RESET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    rd_en        = 1'b0;
    busy         = 1'b0;
    coef_upd_gnt = 1'b0;
    case (state_q)
      RESET: state_d = IDLE;
      IDLE: begin
        in_ready = ~coef_upd_req;
        if (coef_upd_req)  state_d = COEF_UPD;
        else if (in_valid) state_d = COMPUTE;
      end
      COMPUTE: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (zero) begin
          in_ready = ~coef_upd_req;
          if (coef_upd_req)  state_d = UPD_AFTER_LAST;
          else if (in_valid) state_d = COMPUTE;
          else               state_d = IDLE;
        end
      end
      COEF_UPD: begin
        coef_upd_gnt = 1'b1;
        if (!coef_upd_req) state_d = IDLE;
      end
      default: state_d = RESET;
    endcase
  end

  ffe_tap_counter #(.ADDR_SIZE(ADDR_SIZE)) u_tap_counter (
    .ffe_clk  (ffe_clk),
    .rst      (rst),
    .load     (accept),
    .load_val (load_val),
    .dec      (busy & ~zero),
    .count    (rd_addr),
    .zero     (zero)
  );

  always_ff @(posedge ffe_clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b0;
      store_q <= 1'b0;
    end else begin
      first_q <= accept;
      store_q <= last_tap;
    end
  end

`ifdef FFE_MAC_PIPE_EN
  logic clr_pipe_q;
  logic store_pipe_q;

  always_ff @(posedge ffe_clk or posedge rst) begin
    if (rst) begin
      clr_pipe_q   <= 1'b0;
      store_pipe_q <= 1'b0;
    end else begin
      clr_pipe_q   <= first_q;
      store_pipe_q <= store_q;
    end
  end

  assign acc_clr               = clr_pipe_q;
  assign str_out_n_rst_add_reg = store_pipe_q;
`else
  assign acc_clr               = first_q;
  assign str_out_n_rst_add_reg = store_q;
`endif

endmodule

// File: tb/tb_ffe_tap_sequencer.sv
// tb_ffe_tap_sequencer: self-checking bench for ffe_tap_sequencer (NUM_TAPS=8).
// A schedule-based reference model books the expected reads and strobes for
// every accepted sample and derives ready/grant from the handshake rules.
// Honours FFE_MAC_PIPE_EN when the build defines it.
module tb_ffe_tap_sequencer;

  localparam int unsigned NT = 8;
  localparam int unsigned AW = 3;
`ifdef FFE_MAC_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic          ffe_clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW:0]   taps_active = '0;
  logic          coef_upd_req = 1'b0;
  logic          coef_upd_gnt;
  logic          shift_en;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          acc_clr;
  logic          str_out_n_rst_add_reg;
  logic          busy;

  ffe_tap_sequencer #(.NUM_TAPS(NT), .ADDR_SIZE(AW)) dut (
    .ffe_clk               (ffe_clk),
    .rst                   (rst),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .taps_active           (taps_active),
    .coef_upd_req          (coef_upd_req),
    .coef_upd_gnt          (coef_upd_gnt),
    .shift_en              (shift_en),
    .rd_en                 (rd_en),
    .rd_addr               (rd_addr),
    .acc_clr               (acc_clr),
    .str_out_n_rst_add_reg (str_out_n_rst_add_reg),
    .busy                  (busy)
  );

  always #5 ffe_clk = ~ffe_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: future expectations in a ring indexed by cycle.
  int comp_end = -1;
  bit upd = 0;
  bit startup = 0;
  bit exp_rd  [32];
  int exp_addr[32];
  bit exp_clr [32];
  bit exp_str [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      exp_rd[i] = 0; exp_addr[i] = 0; exp_clr[i] = 0; exp_str[i] = 0;
    end
    comp_end = -1;
    upd = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_gnt"},      32'(coef_upd_gnt), 0);
    check({tag, "_shift_en"}, 32'(shift_en), 0);
    check({tag, "_rd_en"},    32'(rd_en), 0);
    check({tag, "_rd_addr"},  32'(rd_addr), 0);
    check({tag, "_acc_clr"},  32'(acc_clr), 0);
    check({tag, "_store"},    32'(str_out_n_rst_add_reg), 0);
    check({tag, "_busy"},     32'(busy), 0);
  endtask

  // Entered and left at posedge+1; inputs drive the current cycle.
  task automatic cycle(input logic v, input logic [AW:0] t, input logic r);
    int slot, n;
    bit last, elig, rdy, acc;
    in_valid = v; taps_active = t; coef_upd_req = r;
    @(negedge ffe_clk);
    slot = cyc % 32;
    last = (cyc == comp_end);
    elig = !startup && !upd && (cyc >= comp_end);
    rdy  = elig && !r;
    acc  = rdy && v;
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("shift_en", 32'(shift_en), 32'(acc));
    check("rd_en",    32'(rd_en), 32'(exp_rd[slot]));
    check("busy",     32'(busy), 32'(exp_rd[slot]));
    check("rd_addr",  32'(rd_addr), 32'(exp_addr[slot]));
    check("acc_clr",  32'(acc_clr), 32'(exp_clr[slot]));
    check("store",    32'(str_out_n_rst_add_reg), 32'(exp_str[slot]));
    check("gnt",      32'(coef_upd_gnt), 32'(upd));
    exp_rd[slot] = 0; exp_addr[slot] = 0; exp_clr[slot] = 0; exp_str[slot] = 0;
    if (acc) begin
      n = (t == 0) ? 1 : ((int'(t) > int'(NT)) ? int'(NT) : int'(t));
      for (int k = 1; k <= n; k++) begin
        exp_rd[(cyc + k) % 32]   = 1;
        exp_addr[(cyc + k) % 32] = n - k;
      end
      exp_clr[(cyc + 1 + PIPE) % 32]     = 1;
      exp_str[(cyc + n + 1 + PIPE) % 32] = 1;
      comp_end = cyc + n;
    end
    if (upd) begin
      if (!r) upd = 0;
    end else if (elig && r && !(PIPE == 1 && last)) begin
      upd = 1;
    end
    startup = 0;
    cyc++;
    @(posedge ffe_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; coef_upd_req = 1'b0; taps_active = '0;
    #1;
    check_all_zero("async_rst");
    clear_model();
    @(posedge ffe_clk);
    #1;
    rst = 1'b0;
    startup = 1;
  endtask

  logic rq;

  initial begin
    clear_model();
    @(posedge ffe_clk);
    @(posedge ffe_clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    startup = 1;
    cycle(0, 0, 0);              // RESET cycle: in_ready low
    cycle(0, 0, 0);

    // Single 4-tap sample then drain
    cycle(1, 4, 0);
    for (int i = 0; i < 7; i++) cycle(0, 4, 0);

    // Continuous valid, back-to-back 4-tap samples
    for (int i = 0; i < 14; i++) cycle(1, 4, 0);
    for (int i = 0; i < 6; i++) cycle(0, 2, 0);

    // Clamp boundaries
    cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    cycle(1, 4'(NT + 3), 0);
    for (int i = 0; i < 11; i++) cycle(0, 5, 0);
    cycle(1, 4'(NT), 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 0);

    // Coefficient update raised mid-sample with valid held high
    cycle(1, 4, 0);
    cycle(1, 4, 0);
    for (int i = 0; i < 6; i++) cycle(1, 4, 1);
    for (int i = 0; i < 8; i++) cycle(1, 3, 0);
    for (int i = 0; i < 4; i++) cycle(0, 3, 0);

    // Update request straight from idle
    cycle(0, 2, 1);
    cycle(1, 2, 1);
    cycle(1, 2, 0);
    for (int i = 0; i < 5; i++) cycle(0, 2, 0);

    // Reset mid-sample: no store afterwards
    cycle(1, 4, 0);
    cycle(0, 4, 0);
    do_reset();
    for (int i = 0; i < 8; i++) cycle(0, 4, 0);

    // Randomized traffic
    rq = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) rq = ~rq;
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle(logic'($urandom_range(0, 3) != 0), (AW+1)'($urandom_range(0, 15)), rq);
    end
    for (int i = 0; i < 12; i++) cycle(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
